// File: rtl/packet_pkg.sv
// Shared packet definitions for the 4-port switch and its egress stages.
// The pkt_t layout matches the switch output concatenation {data, target, source}.
package packet_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 4;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [ADDR_WIDTH-1:0] target;
      logic [ADDR_WIDTH-1:0] source;
   } pkt_t;

   function automatic logic is_onehot(input logic [ADDR_WIDTH-1:0] addr);
      return (addr != '0) && ((addr & (addr - ADDR_WIDTH'(1))) == '0);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO of pkt_t entries.
// The head entry is read combinationally from the storage registers.
module sync_fifo
   import packet_pkg::*;
#(
   parameter int WIDTH = $bits(pkt_t),
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             do_push;
   logic             do_pop;

   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == '0);
   assign level = level_q;
   assign rdata = mem_q[rd_ptr_q];

   // A pop on a full FIFO frees the slot the same-cycle push writes into.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/egress_port_buffer.sv
// Per-port egress stage: route check, FIFO buffering and drain to the sink.
// The switch cannot be backpressured, so misroutes and overflow are counted here.
module egress_port_buffer
   import packet_pkg::*;
#(
   parameter int PORT_ID   = 0,
   parameter int DEPTH     = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid_in,
   input  logic [ADDR_WIDTH-1:0]   source_in,
   input  logic [ADDR_WIDTH-1:0]   target_in,
   input  logic [DATA_WIDTH-1:0]   data_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ADDR_WIDTH-1:0]   out_source,
   output logic [ADDR_WIDTH-1:0]   out_target,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level,
   output logic [CNT_WIDTH-1:0]    pkt_cnt,
   output logic [CNT_WIDTH-1:0]    drop_cnt,
   output logic [CNT_WIDTH-1:0]    misroute_cnt
);

   localparam logic [ADDR_WIDTH-1:0] MY_ADDR = ADDR_WIDTH'(1) << PORT_ID;

   pkt_t in_pkt;
   pkt_t head_pkt;
   logic route_ok;
   logic push;
   logic pop;
   logic misroute;
   logic drop;

   logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
   logic [CNT_WIDTH-1:0] misroute_cnt_q, misroute_cnt_d;

   assign in_pkt = '{data: data_in, target: target_in, source: source_in};

   assign route_ok = is_onehot(target_in) && is_onehot(source_in)
                     && (target_in == MY_ADDR);

   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;
   assign push      = valid_in & route_ok & (~full | pop);
   assign misroute  = valid_in & ~route_ok;
   assign drop      = valid_in & route_ok & full & ~pop;

   sync_fifo #(
      .WIDTH ($bits(pkt_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (in_pkt),
      .pop   (pop),
      .rdata (head_pkt),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   assign out_source = head_pkt.source;
   assign out_target = head_pkt.target;
   assign out_data   = head_pkt.data;

   // Statistics saturate at all-ones instead of wrapping.
   always_comb begin
      pkt_cnt_d      = pkt_cnt_q;
      drop_cnt_d     = drop_cnt_q;
      misroute_cnt_d = misroute_cnt_q;
      if (pop && pkt_cnt_q != '1)
         pkt_cnt_d = pkt_cnt_q + 1'b1;
      if (drop && drop_cnt_q != '1)
         drop_cnt_d = drop_cnt_q + 1'b1;
      if (misroute && misroute_cnt_q != '1)
         misroute_cnt_d = misroute_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt_q      <= '0;
         drop_cnt_q     <= '0;
         misroute_cnt_q <= '0;
      end else begin
         pkt_cnt_q      <= pkt_cnt_d;
         drop_cnt_q     <= drop_cnt_d;
         misroute_cnt_q <= misroute_cnt_d;
      end
   end

   assign pkt_cnt      = pkt_cnt_q;
   assign drop_cnt     = drop_cnt_q;
   assign misroute_cnt = misroute_cnt_q;

endmodule

// File: tb/tb_egress_port_buffer.sv
// Directed bench for egress_port_buffer serving port 2 with an 8-deep FIFO.
// Inputs change and outputs are sampled on the falling edge.
module tb_egress_port_buffer;
   import packet_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  valid_in;
   logic [ADDR_WIDTH-1:0] source_in;
   logic [ADDR_WIDTH-1:0] target_in;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [ADDR_WIDTH-1:0] out_source;
   logic [ADDR_WIDTH-1:0] out_target;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  full;
   logic                  empty;
   logic [3:0]            level;
   logic [15:0]           pkt_cnt;
   logic [15:0]           drop_cnt;
   logic [15:0]           misroute_cnt;

   int checks = 0;
   int fails  = 0;

   egress_port_buffer #(
      .PORT_ID   (2),
      .DEPTH     (8),
      .CNT_WIDTH (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_in     (valid_in),
      .source_in    (source_in),
      .target_in    (target_in),
      .data_in      (data_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_source   (out_source),
      .out_target   (out_target),
      .out_data     (out_data),
      .full         (full),
      .empty        (empty),
      .level        (level),
      .pkt_cnt      (pkt_cnt),
      .drop_cnt     (drop_cnt),
      .misroute_cnt (misroute_cnt)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      valid_in = 1'b0;
      out_ready = 1'b0;
      source_in = 4'b0001;
      target_in = 4'b0100;
      data_in = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (out_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || level !== 4'd0) begin
         fails++;
         $display("FAIL reset_flags: valid=%b empty=%b full=%b level=%0d, want 0 1 0 0",
                  out_valid, empty, full, level);
      end
      checks++;
      if (pkt_cnt !== 16'd0 || drop_cnt !== 16'd0 || misroute_cnt !== 16'd0) begin
         fails++;
         $display("FAIL reset_cnts: pkt=%0d drop=%0d mis=%0d, want 0 0 0",
                  pkt_cnt, drop_cnt, misroute_cnt);
      end
   endtask

   task automatic test_basic();
      do_reset();
      out_ready = 1'b1;
      valid_in = 1'b1;
      source_in = 4'b0001;
      target_in = 4'b0100;
      data_in = 8'hA5;
      @(negedge clk);
      valid_in = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_source !== 4'b0001
          || out_target !== 4'b0100) begin
         fails++;
         $display("FAIL basic_head: valid=%b data=%h src=%b tgt=%b, want 1 a5 0001 0100",
                  out_valid, out_data, out_source, out_target);
      end
      @(negedge clk);
      checks++;
      if (pkt_cnt !== 16'd1 || drop_cnt !== 16'd0 || empty !== 1'b1) begin
         fails++;
         $display("FAIL basic_cnt: pkt=%0d drop=%0d empty=%b, want 1 0 1",
                  pkt_cnt, drop_cnt, empty);
      end
   endtask

   task automatic test_misroute();
      logic [3:0] srcs [3];
      logic [3:0] tgts [3];
      srcs = '{4'b0001, 4'b0001, 4'b0000};
      tgts = '{4'b0010, 4'b0110, 4'b0100};
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         valid_in = 1'b1;
         source_in = srcs[i];
         target_in = tgts[i];
         data_in = 8'(8'h10 + i);
         @(negedge clk);
         checks++;
         if (empty !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL misroute_stored_%0d: empty=%b valid=%b, want 1 0",
                     i, empty, out_valid);
         end
      end
      valid_in = 1'b0;
      checks++;
      if (misroute_cnt !== 16'd3 || pkt_cnt !== 16'd0) begin
         fails++;
         $display("FAIL misroute_cnt: mis=%0d pkt=%0d, want 3 0", misroute_cnt, pkt_cnt);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      source_in = 4'b1000;
      target_in = 4'b0100;
      for (int i = 0; i < 10; i++) begin
         valid_in = 1'b1;
         data_in = 8'(i);
         @(negedge clk);
      end
      valid_in = 1'b0;
      checks++;
      if (full !== 1'b1 || level !== 4'd8 || drop_cnt !== 16'd2) begin
         fails++;
         $display("FAIL overflow_fill: full=%b level=%0d drop=%0d, want 1 8 2",
                  full, level, drop_cnt);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
            fails++;
            $display("FAIL overflow_order_%0d: valid=%b data=%0d, want 1 %0d",
                     i, out_valid, out_data, i);
         end
         @(negedge clk);
      end
      checks++;
      if (pkt_cnt !== 16'd8 || empty !== 1'b1) begin
         fails++;
         $display("FAIL overflow_drain: pkt=%0d empty=%b, want 8 1", pkt_cnt, empty);
      end
   endtask

   task automatic test_full_simul();
      logic [7:0] exp [8];
      exp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'h3C};
      do_reset();
      source_in = 4'b0010;
      target_in = 4'b0100;
      for (int i = 0; i < 8; i++) begin
         valid_in = 1'b1;
         data_in = 8'(i);
         @(negedge clk);
      end
      out_ready = 1'b1;
      data_in = 8'h3C;
      @(negedge clk);
      valid_in = 1'b0;
      checks++;
      if (level !== 4'd8 || full !== 1'b1 || drop_cnt !== 16'd0) begin
         fails++;
         $display("FAIL full_simul_level: level=%0d full=%b drop=%0d, want 8 1 0",
                  level, full, drop_cnt);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp[i]) begin
            fails++;
            $display("FAIL full_simul_order_%0d: valid=%b data=%h, want 1 %h",
                     i, out_valid, out_data, exp[i]);
         end
         @(negedge clk);
      end
      checks++;
      if (empty !== 1'b1 || pkt_cnt !== 16'd9) begin
         fails++;
         $display("FAIL full_simul_end: empty=%b pkt=%0d, want 1 9", empty, pkt_cnt);
      end
   endtask

   task automatic test_stall_wrap();
      int         sent = 0;
      int         rcvd = 0;
      int         cyc  = 0;
      logic       stalled = 1'b0;
      logic [7:0] held_data = '0;
      logic [3:0] held_src = '0;
      do_reset();
      source_in = 4'b0001;
      target_in = 4'b0100;
      while (rcvd < 100 && cyc < 2000) begin
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== held_data || out_source !== held_src) begin
               fails++;
               $display("FAIL stall_stable: valid=%b data=%0d src=%b, want 1 %0d %b",
                        out_valid, out_data, out_source, held_data, held_src);
            end
         end
         out_ready = 1'($urandom_range(1, 0));
         if (out_valid && out_ready) begin
            checks++;
            if (out_data !== 8'(rcvd)) begin
               fails++;
               $display("FAIL stall_order: data=%0d, want %0d", out_data, rcvd);
            end
            rcvd++;
         end
         stalled = out_valid & ~out_ready;
         held_data = out_data;
         held_src = out_source;
         if (sent < 100 && !full) begin
            valid_in = 1'b1;
            data_in = 8'(sent);
            source_in = (sent % 2 == 0) ? 4'b0001 : 4'b1000;
            sent++;
         end else begin
            valid_in = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      valid_in = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (rcvd != 100) begin
         fails++;
         $display("FAIL stall_timeout: received=%0d, want 100", rcvd);
      end
      checks++;
      if (pkt_cnt !== 16'd100 || drop_cnt !== 16'd0 || empty !== 1'b1) begin
         fails++;
         $display("FAIL stall_cnt: pkt=%0d drop=%0d empty=%b, want 100 0 1",
                  pkt_cnt, drop_cnt, empty);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      source_in = 4'b0100;
      target_in = 4'b0100;
      for (int i = 0; i < 6; i++) begin
         valid_in = 1'b1;
         data_in = 8'(8'h40 + i);
         @(negedge clk);
      end
      target_in = 4'b0001;
      @(negedge clk);
      valid_in = 1'b0;
      target_in = 4'b0100;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (level !== 4'd5 || pkt_cnt !== 16'd1 || misroute_cnt !== 16'd1) begin
         fails++;
         $display("FAIL reset_mid_pre: level=%0d pkt=%0d mis=%0d, want 5 1 1",
                  level, pkt_cnt, misroute_cnt);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (empty !== 1'b1 || out_valid !== 1'b0 || level !== 4'd0 || pkt_cnt !== 16'd0
          || drop_cnt !== 16'd0 || misroute_cnt !== 16'd0) begin
         fails++;
         $display("FAIL reset_mid_post: empty=%b valid=%b level=%0d pkt=%0d drop=%0d mis=%0d",
                  empty, out_valid, level, pkt_cnt, drop_cnt, misroute_cnt);
      end
      valid_in = 1'b1;
      data_in = 8'h77;
      out_ready = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h77 || level !== 4'd1) begin
         fails++;
         $display("FAIL reset_mid_after: valid=%b data=%h level=%0d, want 1 77 1",
                  out_valid, out_data, level);
      end
      @(negedge clk);
      checks++;
      if (pkt_cnt !== 16'd1 || empty !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid_deliver: pkt=%0d empty=%b, want 1 1", pkt_cnt, empty);
      end
   endtask

   initial begin
      rst = 1'b1;
      valid_in = 1'b0;
      out_ready = 1'b0;
      source_in = '0;
      target_in = '0;
      data_in = '0;
      test_reset();
      test_basic();
      test_misroute();
      test_overflow();
      test_full_simul();
      test_stall_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/egress_port_buffer.md
Name: egress_port_buffer

Overview:
- Per-port egress stage directly downstream of the 4-port switch.
- Consumes one switch output port (valid/source/target/data) and checks the packet is addressed to this port.
- Buffers accepted packets in a FIFO and drains them to the downstream sink over a valid/ready handshake.
- The switch output has no backpressure, so overflow and misroutes are dropped and counted here.

Parameters:
- PORT_ID, 0: index of the switch port this instance serves (0..3).
- DEPTH, 8: FIFO entries; power of two, at least 2.
- CNT_WIDTH, 16: width of the statistics counters.
- DATA_WIDTH, ADDR_WIDTH: taken from packet_pkg, not overridden per instance.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  switch output valid for this port.
- source_in  in  ADDR_WIDTH  one-hot source port.
- target_in  in  ADDR_WIDTH  one-hot target port.
- data_in  in  DATA_WIDTH  payload.
- out_valid  out  1  head packet available.
- out_ready  in  1  sink accepts the head packet this cycle.
- out_source  out  ADDR_WIDTH  head source.
- out_target  out  ADDR_WIDTH  head target.
- out_data  out  DATA_WIDTH  head payload.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  $clog2(DEPTH)+1  current occupancy.
- pkt_cnt  out  CNT_WIDTH  packets delivered (pops).
- drop_cnt  out  CNT_WIDTH  packets dropped because the FIFO was full.
- misroute_cnt  out  CNT_WIDTH  packets dropped because of a bad target or source.

Behaviour:
- Reset: while rst=1 at a clock edge, pointers and level go to 0 and all counters go to 0. Outputs then read out_valid=0, empty=1, full=0. out_* payload is don't-care while out_valid=0. Reset mid-stream flushes the FIFO; in-flight packets are lost and not counted.
- Route check: a valid_in beat is misrouted if target_in != (1<<PORT_ID), target_in is not one-hot, or source_in is not one-hot. Misrouted beats are never stored, and misroute_cnt increments by 1. The misroute check takes priority over the full check.
- Push: push = valid_in & route_ok & (!full | pop).
- Overflow: a beat with valid_in & route_ok & full & !pop is dropped, and drop_cnt increments by 1.
- Pop: pop = out_valid & out_ready. pkt_cnt increments by 1 on each pop.
- FWFT: out_valid = !empty. out_* show the head entry combinationally from the storage registers. Latency from accepted push to out_valid is 1 cycle.
- Stall: while out_valid=1 and out_ready=0, out_* hold stable. out_valid never deasserts without a pop or reset.
- Simultaneous push and pop:
  - When full: both occur and level stays DEPTH; the pop frees the slot in the same cycle.
  - When empty: no pop is possible; the push lands and out_valid rises next cycle.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. level tracks occupancy with an extra bit to distinguish full from empty. full = (level==DEPTH), empty = (level==0).
- Counters saturate at all-ones and never wrap.
- out_ready is ignored while out_valid=0.

Decomposition:
- packet_pkg supplies DATA_WIDTH and ADDR_WIDTH.
- Add to packet_pkg: a packed struct pkt_t {data, target, source}, matching the switch's {data, target, source} output concatenation.
- Add to packet_pkg: a function is_onehot(addr).
- One sub-module, sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level, FWFT head output), stores pkt_t.
- Route check and counters stay in egress_port_buffer.

Test Plan:
- Basic pass (PORT_ID=2, out_ready=1): one beat source=0001, target=0100, data=0xA5 -> next cycle out_valid=1, out_data=0xA5, out_source=0001; pkt_cnt=1, drop_cnt=0.
- Misroute: target=0010 (other port), then target=0110 (not one-hot), then source=0000 -> nothing stored, empty stays 1, misroute_cnt=3.
- Overflow (DEPTH=8, out_ready=0): 10 valid beats, data 0..9 -> full=1, level=8, drop_cnt=2. Then out_ready=1 -> data 0..7 in order, pkt_cnt=8, empty=1.
- Full plus simultaneous traffic: with the FIFO full, assert out_ready=1 and valid_in in the same cycle (data=0x3C) -> level stays 8, drop_cnt unchanged, 0x3C delivered last.
- Stall and wrap: random out_ready (50%) over 100 in-order beats -> out_* stable whenever out_valid & !out_ready, all 100 delivered in order across pointer wrap, pkt_cnt=100.
- Reset mid-operation: rst=1 for 1 cycle with level=5 and counters nonzero -> next cycle empty=1, out_valid=0, level=0, all counters=0; a subsequent beat is delivered normally.
